s820_resp_compactor: RTL and testbench

S820_RESP_COMPACTOR -- requirements
Module: s820_resp_compactor

---
 rtl/s820_resp_compactor.sv | 114 +++++++++++
 tb/tb_s820_resp_compactor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/s820_resp_compactor.sv
// s820 response compactor: 19-bit MISR folds LEN valid response vectors, then compares to a golden signature.
// Latency: one cycle per valid vector; DONE/MATCH one cycle after the last accepted vector.
// Backpressure: none; RESP_VLD gaps simply stall the run indefinitely, and there is no timeout.
//
// Ports:
//   CK, RST            clock and synchronous active-high reset
//   START, ABORT, LEN  run control; LEN is the vector count, sampled when START is accepted
//   RESP_IN, RESP_VLD  response vector stream (G302 is bit 0)
//   EXP_SIG            golden signature, sampled in the cycle the run completes
//   SIG, REMAIN        MISR contents and the count of vectors still to go
//   BUSY, DONE, MATCH  state flags and the registered compare result
module s820_resp_compactor #(
    parameter logic [18:0] SEED = 19'h00000,
    parameter logic [18:0] POLY = 19'h00027
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic [7:0]  LEN,
    input  logic [18:0] RESP_IN,
    input  logic        RESP_VLD,
    input  logic [18:0] EXP_SIG,
    output logic [18:0] SIG,
    output logic [7:0]  REMAIN,
    output logic        BUSY,
    output logic        DONE,
    output logic        MATCH
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [18:0] r_sig;
    logic [7:0]  r_remain;
    logic        r_match;

    logic [18:0] w_sig_step;
    logic        w_abort;
    logic        w_start_ok;
    logic        w_consume;
    logic        w_last;

    // One MISR shift: shift left, fold the outgoing MSB back through POLY, inject the response.
    assign w_sig_step = {r_sig[17:0], 1'b0} ^ (r_sig[18] ? POLY : 19'h00000) ^ RESP_IN;

    // ABORT only matters once a run has been started; in IDLE it is a no-op.
    assign w_abort    = ABORT && (r_state != S_IDLE);
    // START is honoured in IDLE and DONE (restart), never mid-run, and loses to ABORT.
    assign w_start_ok = START && !w_abort && (r_state != S_RUN);
    assign w_consume  = (r_state == S_RUN) && RESP_VLD && !ABORT;
    // REMAIN of 0 cannot occur in RUN, but treating it as "last" keeps the FSM from sticking.
    assign w_last     = w_consume && (r_remain <= 8'd1);

    // State register
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = (LEN != 8'd0) ? S_RUN : S_DONE;
        end else if (w_last) begin
            w_state_nxt = S_DONE;
        end
    end

    // Datapath: MISR, remaining count and the compare result.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_sig    <= SEED;
            r_remain <= 8'd0;
            r_match  <= 1'b0;
        end else if (w_abort) begin
            // Signature is kept for inspection after a cancelled run.
            r_remain <= 8'd0;
            r_match  <= 1'b0;
        end else if (w_start_ok) begin
            r_sig    <= SEED;
            r_remain <= LEN;
            // A zero-length run completes immediately against the seed.
            r_match  <= (LEN == 8'd0) && (SEED == EXP_SIG);
        end else if (w_consume) begin
            r_sig    <= w_sig_step;
            if (r_remain != 8'd0) begin
                r_remain <= r_remain - 8'd1;
            end
            r_match  <= w_last && (w_sig_step == EXP_SIG);
        end
    end

    // Outputs
    always_comb begin
        SIG    = r_sig;
        REMAIN = r_remain;
        BUSY   = (r_state == S_RUN);
        DONE   = (r_state == S_DONE);
        MATCH  = r_match && (r_state == S_DONE);
    end

endmodule

// File: tb/tb_s820_resp_compactor.sv
// Directed self-checking bench for s820_resp_compactor.
// Inputs change #1 after the rising edge; outputs are checked at that same point.
// Each scenario task carries its own inline comparisons.
module tb_s820_resp_compactor;

    logic        CK;
    logic        RST;
    logic        START;
    logic        ABORT;
    logic [7:0]  LEN;
    logic [18:0] RESP_IN;
    logic        RESP_VLD;
    logic [18:0] EXP_SIG;
    logic [18:0] SIG;
    logic [7:0]  REMAIN;
    logic        BUSY;
    logic        DONE;
    logic        MATCH;

    int total;
    int bad;

    s820_resp_compactor dut (
        .CK       (CK),
        .RST      (RST),
        .START    (START),
        .ABORT    (ABORT),
        .LEN      (LEN),
        .RESP_IN  (RESP_IN),
        .RESP_VLD (RESP_VLD),
        .EXP_SIG  (EXP_SIG),
        .SIG      (SIG),
        .REMAIN   (REMAIN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .MATCH    (MATCH)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic quiet;
        RST = 0; START = 0; ABORT = 0; RESP_VLD = 0; RESP_IN = '0; LEN = '0;
    endtask

    task automatic test_reset;
        quiet();
        EXP_SIG = '0;
        RST = 1; START = 1; LEN = 8'd7;
        tick();
        tick();
        quiet();
        total++; if (SIG !== 19'h00000) begin bad++; $display("FAIL reset_sig got=%h want=%h", SIG, 19'h00000); end
        total++; if (REMAIN !== 8'd0) begin bad++; $display("FAIL reset_remain got=%0d want=0", REMAIN); end
        total++; if (BUSY !== 1'b0 || DONE !== 1'b0 || MATCH !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b want=000", BUSY, DONE, MATCH); end
    endtask

    task automatic test_single;
        START = 1; LEN = 8'd1;
        tick();
        quiet();
        total++; if (BUSY !== 1'b1 || REMAIN !== 8'd1 || SIG !== 19'h0) begin bad++; $display("FAIL single_start got busy=%b rem=%0d sig=%h want 1/1/0", BUSY, REMAIN, SIG); end
        RESP_IN = 19'h00001; RESP_VLD = 1; EXP_SIG = 19'h00001;
        tick();
        quiet();
        total++; if (SIG !== 19'h00001) begin bad++; $display("FAIL single_sig got=%h want=00001", SIG); end
        total++; if (DONE !== 1'b1 || BUSY !== 1'b0 || REMAIN !== 8'd0) begin bad++; $display("FAIL single_flags got done=%b busy=%b rem=%0d want 1/0/0", DONE, BUSY, REMAIN); end
        total++; if (MATCH !== 1'b1) begin bad++; $display("FAIL single_match got=%b want=1", MATCH); end
    endtask

    task automatic test_poly;
        START = 1; LEN = 8'd2;
        tick();
        quiet();
        RESP_IN = 19'h40000; RESP_VLD = 1;
        tick();
        quiet();
        total++; if (SIG !== 19'h40000 || REMAIN !== 8'd1 || BUSY !== 1'b1) begin bad++; $display("FAIL poly_first got sig=%h rem=%0d busy=%b want 40000/1/1", SIG, REMAIN, BUSY); end
        RESP_IN = 19'h00000; RESP_VLD = 1; EXP_SIG = 19'h00027;
        tick();
        quiet();
        total++; if (SIG !== 19'h00027) begin bad++; $display("FAIL poly_sig got=%h want=00027", SIG); end
        total++; if (DONE !== 1'b1 || MATCH !== 1'b1) begin bad++; $display("FAIL poly_done got done=%b match=%b want 1/1", DONE, MATCH); end
    endtask

    task automatic test_gaps;
        logic [18:0] esig;
        logic [7:0]  erem;
        logic        edone;
        START = 1; LEN = 8'd3; EXP_SIG = 19'h00000;
        tick();
        quiet();
        for (int c = 1; c <= 7; c++) begin
            RESP_IN  = 19'h00001;
            RESP_VLD = (c == 1 || c == 3 || c == 6 || c == 7);
            case (c)
                1, 2:    begin esig = 19'h00001; erem = 8'd2; end
                3, 4, 5: begin esig = 19'h00003; erem = 8'd1; end
                default: begin esig = 19'h00007; erem = 8'd0; end
            endcase
            edone = (c >= 6);
            tick();
            quiet();
            total++;
            if (SIG !== esig || REMAIN !== erem || DONE !== edone || BUSY !== !edone) begin
                bad++;
                $display("FAIL gaps_c%0d got sig=%h rem=%0d done=%b busy=%b want sig=%h rem=%0d done=%b", c, SIG, REMAIN, DONE, BUSY, esig, erem, edone);
            end
        end
        total++; if (MATCH !== 1'b0) begin bad++; $display("FAIL gaps_mismatch got=%b want=0", MATCH); end
    endtask

    task automatic test_len0;
        ABORT = 1;
        tick();
        quiet();
        total++; if (DONE !== 1'b0 || BUSY !== 1'b0 || SIG !== 19'h00007 || REMAIN !== 8'd0) begin bad++; $display("FAIL abort_done got done=%b busy=%b sig=%h rem=%0d want 0/0/00007/0", DONE, BUSY, SIG, REMAIN); end
        START = 1; LEN = 8'd0; EXP_SIG = 19'h00000;
        tick();
        quiet();
        total++; if (DONE !== 1'b1 || MATCH !== 1'b1 || SIG !== 19'h0 || BUSY !== 1'b0) begin bad++; $display("FAIL len0 got done=%b match=%b sig=%h busy=%b want 1/1/0/0", DONE, MATCH, SIG, BUSY); end
        START = 1; LEN = 8'd0; EXP_SIG = 19'h00005;
        tick();
        quiet();
        total++; if (DONE !== 1'b1 || MATCH !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL len0_miss got done=%b match=%b busy=%b want 1/0/0", DONE, MATCH, BUSY); end
    endtask

    task automatic test_idle_ignore;
        ABORT = 1;
        tick();
        quiet();
        // Now IDLE; ABORT and response traffic must not disturb anything.
        ABORT = 1; RESP_VLD = 1; RESP_IN = 19'h12345;
        tick();
        quiet();
        total++; if (SIG !== 19'h0 || REMAIN !== 8'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL idle_ignore got sig=%h rem=%0d busy=%b done=%b want 0/0/0/0", SIG, REMAIN, BUSY, DONE); end
    endtask

    task automatic test_reset_mid;
        START = 1; LEN = 8'd8;
        tick();
        quiet();
        for (int i = 0; i < 3; i++) begin
            RESP_IN = 19'h00001; RESP_VLD = 1;
            tick();
        end
        quiet();
        total++; if (REMAIN !== 8'd5 || SIG !== 19'h00007) begin bad++; $display("FAIL mid_run got rem=%0d sig=%h want 5/00007", REMAIN, SIG); end
        RST = 1; START = 1; LEN = 8'd3; RESP_VLD = 1; RESP_IN = 19'h00001; ABORT = 1;
        tick();
        quiet();
        total++; if (BUSY !== 1'b0 || DONE !== 1'b0 || SIG !== 19'h0 || REMAIN !== 8'd0 || MATCH !== 1'b0) begin bad++; $display("FAIL rst_mid got busy=%b done=%b sig=%h rem=%0d match=%b want 0/0/0/0/0", BUSY, DONE, SIG, REMAIN, MATCH); end
        START = 1; LEN = 8'd4;
        tick();
        quiet();
        RESP_IN = 19'h00005; RESP_VLD = 1;
        tick();
        quiet();
        ABORT = 1; START = 1; LEN = 8'd9; RESP_VLD = 1; RESP_IN = 19'h00003;
        tick();
        quiet();
        total++; if (BUSY !== 1'b0 || DONE !== 1'b0 || SIG !== 19'h00005 || REMAIN !== 8'd0) begin bad++; $display("FAIL abort_start got busy=%b done=%b sig=%h rem=%0d want 0/0/00005/0", BUSY, DONE, SIG, REMAIN); end
    endtask

    task automatic test_restart;
        START = 1; LEN = 8'd1;
        tick();
        quiet();
        RESP_IN = 19'h00009; RESP_VLD = 1; EXP_SIG = 19'h00009;
        tick();
        quiet();
        total++; if (DONE !== 1'b1 || MATCH !== 1'b1 || SIG !== 19'h00009) begin bad++; $display("FAIL pre_restart got done=%b match=%b sig=%h want 1/1/00009", DONE, MATCH, SIG); end
        START = 1; LEN = 8'd4;
        tick();
        quiet();
        total++; if (BUSY !== 1'b1 || DONE !== 1'b0 || SIG !== 19'h0 || REMAIN !== 8'd4 || MATCH !== 1'b0) begin bad++; $display("FAIL restart got busy=%b done=%b sig=%h rem=%0d match=%b want 1/0/0/4/0", BUSY, DONE, SIG, REMAIN, MATCH); end
        START = 1; LEN = 8'd2;
        tick();
        quiet();
        total++; if (REMAIN !== 8'd4 || BUSY !== 1'b1) begin bad++; $display("FAIL start_in_run got rem=%0d busy=%b want 4/1", REMAIN, BUSY); end
        START = 1; LEN = 8'd9; RESP_VLD = 1; RESP_IN = 19'h00003;
        tick();
        quiet();
        total++; if (REMAIN !== 8'd3 || SIG !== 19'h00003) begin bad++; $display("FAIL start_vld_in_run got rem=%0d sig=%h want 3/00003", REMAIN, SIG); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        quiet();
        EXP_SIG = '0;
        test_reset();
        test_single();
        test_poly();
        test_gaps();
        test_len0();
        test_idle_ignore();
        test_reset_mid();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
